// File: rtl/elastic_pipe_fifo_pkg.sv
// Shared sizing constants and helpers for the elastic pipe FIFO.
// Producer stages import the defaults here so their AF_MARGIN tracks their own latency.
package elastic_pipe_fifo_pkg;

  localparam int DEFAULT_WIDTH     = 32;
  localparam int DEFAULT_DEPTH     = 4;
  localparam int DEFAULT_AF_MARGIN = 2;

  // Pointer width: address bits plus one wrap bit.
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/elastic_pipe_fifo_if.sv
// Handshake, flush and status bundle between a producer/consumer pair and the FIFO.
interface elastic_pipe_fifo_if
  import elastic_pipe_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
);

  localparam int CNT_W = fifo_cnt_w(DEPTH);

  logic             flush;
  logic             in_vld;
  logic             in_rdy;
  logic [WIDTH-1:0] in_data;
  logic             out_vld;
  logic             out_rdy;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] count;
  logic             almost_full;

  modport slave (
    input  flush, in_vld, in_data, out_rdy,
    output in_rdy, out_vld, out_data, count, almost_full
  );

  modport master (
    output flush, in_vld, in_data, out_rdy,
    input  in_rdy, out_vld, out_data, count, almost_full
  );

endinterface

// File: rtl/elastic_fifo_ram.sv
// DEPTH x WIDTH storage with one write port and an asynchronous read port.
// No control logic lives here so it can be replaced by a vendor macro.
module elastic_fifo_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/elastic_pipe_fifo.sv
// Elastic buffer behind fixed-latency stages: absorbs consumer stalls and
// reports occupancy/almost_full so the producer can stop issuing in time.
module elastic_pipe_fifo
  import elastic_pipe_fifo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AF_MARGIN = DEFAULT_AF_MARGIN
) (
  input  logic                clk,
  input  logic                rst,
  elastic_pipe_fifo_if.slave  bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = fifo_ptr_w(DEPTH);
  localparam int CNT_W = fifo_cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] AF_LEVEL = CNT_W'(DEPTH - AF_MARGIN);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic ram_we;

  // Flags depend only on registered pointers, so in_rdy never sees out_rdy.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign push   = bus.in_vld & ~full;
  assign pop    = ~empty & bus.out_rdy;
  assign ram_we = push & ~bus.flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  elastic_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (bus.in_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (bus.out_data)
  );

  assign bus.in_rdy      = ~full;
  assign bus.out_vld     = ~empty;
  assign bus.count       = count_q;
  assign bus.almost_full = (count_q >= AF_LEVEL);

endmodule

// File: tb/tb_elastic_pipe_fifo.sv
// Directed plus random stimulus against a queue-based reference of the FIFO.
module tb_elastic_pipe_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int AFM   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  elastic_pipe_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  elastic_pipe_fifo #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AF_MARGIN (AFM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [WIDTH-1:0] model_q [$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  bit  watch55 = 0;
  bit  seen55  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int sz;
    sz = model_q.size();
    check("out_vld", 32'(bus.out_vld), 32'(sz != 0));
    check("in_rdy", 32'(bus.in_rdy), 32'(sz < DEPTH));
    check("count", 32'(bus.count), 32'(sz));
    check("almost_full", 32'(bus.almost_full), 32'(sz >= DEPTH - AFM));
    if (sz != 0) begin
      check("out_data", bus.out_data, model_q[0]);
    end
    if (watch55 && bus.out_vld === 1'b1 && bus.out_data === 32'h55) begin
      seen55 = 1;
    end
  endtask

  // Apply one cycle of inputs, advance the model, then check at the falling edge.
  task automatic cycle(input bit r, input bit f, input bit iv,
                       input logic [31:0] d, input bit ordy);
    int  sz;
    bit  do_push;
    bit  do_pop;
    rst         = r;
    bus.flush   = f;
    bus.in_vld  = iv;
    bus.in_data = d;
    bus.out_rdy = ordy;
    sz      = model_q.size();
    do_push = !r && !f && iv && (sz < DEPTH);
    do_pop  = !r && !f && ordy && (sz > 0);
    if (do_push || do_pop || r || f) begin
      $display("cyc=%0d rst=%0d flush=%0d push=%0d din=%h pop=%0d dout=%h cnt_before=%0d",
               cyc, r, f, do_push, d, do_pop, (sz > 0) ? model_q[0] : 32'h0, sz);
    end
    if (r || f) begin
      model_q.delete();
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(d);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    bus.flush   = 1'b0;
    bus.in_vld  = 1'b0;
    bus.in_data = '0;
    bus.out_rdy = 1'b0;
    @(negedge clk);

    // Reset for two cycles, then idle.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 0);

    // Fill with consumer stalled; fifth push must be refused.
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 32'hA0 + 32'(i), 0);
    cycle(0, 0, 1, 32'hA4, 0);
    // Drain in order.
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1);

    // Streaming across pointer wrap.
    for (int i = 0; i < 20; i++) cycle(0, 0, 1, 32'h100 + 32'(i), 1);
    cycle(0, 0, 0, 0, 1);

    // Full plus pop: no push that cycle, then push+pop together.
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 32'hB0 + 32'(i), 0);
    cycle(0, 0, 1, 32'hB4, 1);
    cycle(0, 0, 1, 32'hB5, 1);
    cycle(0, 0, 1, 32'hB6, 1);

    // Flush at count=3 with a concurrent push of 0x55.
    watch55 = 1;
    cycle(0, 1, 1, 32'h55, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 1, 32'hC0, 0);
    cycle(0, 0, 0, 0, 1);
    watch55 = 0;
    check("flushed_0x55_seen", 32'(seen55), 32'd0);

    // Reset mid-traffic at count=2, then 0x77 comes out first.
    cycle(0, 0, 1, 32'hD0, 0);
    cycle(0, 0, 1, 32'hD1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 32'hD2 + 32'(i), 1);
    cycle(1, 0, 1, 32'hDF, 1);
    cycle(0, 0, 1, 32'h77, 0);
    check("post_reset_head", bus.out_data, 32'h77);
    cycle(0, 0, 1, 32'h78, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(63) == 0), ($urandom_range(15) == 0),
            ($urandom_range(3) != 0), $urandom, ($urandom_range(2) != 0));
    end
    for (int i = 0; i < DEPTH + 1; i++) cycle(0, 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/elastic_pipe_fifo.md
Name: elastic_pipe_fifo

Overview:
- Small synchronous elastic buffer with valid/ready handshake on both sides.
- Sits downstream of fixed-latency delay/register stages (DFF2 chains, optional pipeline registers).
- Absorbs back-pressure that those stages cannot stall for, so a producer with fixed latency can drive a consumer that may stall.
- Provides occupancy and almost-full outputs so the producer can stop issuing early enough to cover its own pipeline depth.

Parameters:
- WIDTH, 32: payload bits per entry.
- DEPTH, 4: number of entries. Must be a power of two, 2..64.
- AF_MARGIN, 2: almost_full asserts when count >= DEPTH-AF_MARGIN. Legal range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous discard of all entries.
- in_vld  in  1  producer presents in_data.
- in_rdy  out  1  buffer can accept this cycle.
- in_data  in  WIDTH  write payload.
- out_vld  out  1  out_data holds the oldest entry.
- out_rdy  in  1  consumer takes the entry this cycle.
- out_data  out  WIDTH  head payload.
- count  out  $clog2(DEPTH+1)  current occupancy.
- almost_full  out  1  count >= DEPTH-AF_MARGIN.

Behaviour:
- State:
  - wr_ptr and rd_ptr, each log2(DEPTH)+1 bits; the extra MSB is the wrap bit.
  - Storage array mem[DEPTH].
  - count register.
- push = in_vld & in_rdy; pop = out_vld & out_rdy.
- Derived flags:
  - empty = (wr_ptr == rd_ptr).
  - full = low bits equal and wrap bits differ.
- Outputs:
  - in_rdy = ~full, purely from registered state, with no combinational path from out_rdy.
  - out_vld = ~empty.
  - out_data = mem[rd_ptr low bits], combinational read of a registered array.
- Latency: a push at edge N gives out_vld=1 in the cycle after edge N. There is no same-cycle bypass from input to output.
- Throughput: one push and one pop per cycle sustained when neither full nor empty.
- Full with out_rdy=1: in_rdy is still 0 that cycle. The pop frees a slot, and in_rdy=1 next cycle.
- Empty with in_vld=1: out_vld stays 0 that cycle. The entry appears next cycle.
- Simultaneous push and pop (not full, not empty): both pointers advance and count is unchanged.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Held on both or neither.
- Pointers wrap modulo 2*DEPTH via natural overflow. No special wrap logic is needed.
- flush:
  - rd_ptr <= wr_ptr and count <= 0 at the edge.
  - Takes priority over push and pop in the same cycle; a concurrent push is dropped.
  - Outputs are valid again the next cycle: out_vld=0, in_rdy=1.
- rst:
  - wr_ptr=0, rd_ptr=0, count=0.
  - Outputs after reset: out_vld=0, in_rdy=1, almost_full=0 (AF_MARGIN<DEPTH), count=0.
  - rst has priority over flush and the handshakes.
  - Reset mid-traffic discards all contents with no partial entry left.
  - mem contents are not reset. out_data is don't-care while out_vld=0.
- X rule: in_data is sampled only when push=1. in_vld must not be X while in_rdy=1.

Decomposition:
- Shared package / struct.v defines:
  - FIFO_PTR_W(depth) macro = log2(depth)+1.
  - Default DEPTH and AF_MARGIN constants, so producer stages size AF_MARGIN to their own latency.
- One sub-module, elastic_fifo_ram:
  - DEPTH x WIDTH storage.
  - Write port: we, waddr, wdata.
  - Asynchronous read port: raddr to rdata.
  - Contains no control logic, so it can later be swapped for a macro.
- Pointer and count registers use DFF2 instances, with en = push/pop/flush.

Test Plan:
- Reset, then idle: after rst held 2 cycles, expect out_vld=0, in_rdy=1, count=0, almost_full=0, held for 10 idle cycles.
- Fill/drain (DEPTH=4, AF_MARGIN=2):
  - Push 0xA0..0xA3 with out_rdy=0. Expect count 1,2,3,4; almost_full from count=2; in_rdy=0 at count=4.
  - A 5th in_vld is not accepted.
  - Then out_rdy=1: expect out_data A0,A1,A2,A3 in order; out_vld=0 after.
- Streaming across wrap: in_vld=out_rdy=1 for 20 cycles with an incrementing payload. Expect count steady at 1, in-order output with one-cycle latency, pointers wrap twice with no loss.
- Full plus pop: at count=4, assert in_vld and out_rdy. Expect no push that cycle and count=3. Next cycle in_rdy=1; push and pop together keep count=3.
- Flush with concurrent push: at count=3, assert flush and in_vld=1 (payload 0x55). Expect next cycle count=0, out_vld=0, in_rdy=1, and 0x55 never appears at out_data.
- Reset mid-operation: at count=2 with streaming active, pulse rst one cycle. Expect count=0 and out_vld=0 next cycle. A subsequent push of 0x77 is output first.
